// File: rtl/color_classifier.sv
// color_classifier: steps the colour sensor through R/G/B filters,
// captures one count per channel and reports the dominant colour.
module color_classifier #(
   parameter int         SETTLE_CYCLES = 50000,
   parameter logic [7:0] MARGIN        = 8'd10,
   parameter logic [7:0] DARK_THRESH   = 8'd200
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [7:0] count_in,
   output logic       s2,
   output logic       s3,
   output logic [7:0] red_val,
   output logic [7:0] green_val,
   output logic [7:0] blue_val,
   output logic [1:0] color,
   output logic       color_valid
);

   localparam int TW = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [TW-1:0] LAST = TW'(SETTLE_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SEL_R  = 3'd1,
      SEL_G  = 3'd2,
      SEL_B  = 3'd3,
      DECIDE = 3'd4
   } state_t;

   state_t        state;
   state_t        state_next;
   logic [TW-1:0] dwell_timer;
   logic          dwell_last;
   logic          in_sel;
   logic [7:0]    r_s;
   logic [7:0]    g_s;
   logic [7:0]    b_s;
   logic          r_win;
   logic          g_win;
   logic          b_win;
   logic [1:0]    color_next;
   logic [1:0]    sel_next;

   assign dwell_last = (dwell_timer == LAST);
   assign in_sel     = (state == SEL_R) || (state == SEL_G) ||
                       (state == SEL_B);

   // State register; reset has priority over everything else.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: dropping en aborts a frame unless already in DECIDE.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: begin
            if (en) state_next = SEL_R;
         end
         SEL_R: begin
            if (!en)             state_next = IDLE;
            else if (dwell_last) state_next = SEL_G;
         end
         SEL_G: begin
            if (!en)             state_next = IDLE;
            else if (dwell_last) state_next = SEL_B;
         end
         SEL_B: begin
            if (!en)             state_next = IDLE;
            else if (dwell_last) state_next = DECIDE;
         end
         DECIDE: begin
            state_next = en ? SEL_R : IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Dwell timer restarts on every state entry and only counts in SEL states.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dwell_timer <= '0;
      end else if (!in_sel || (state_next != state)) begin
         dwell_timer <= '0;
      end else begin
         dwell_timer <= dwell_timer + TW'(1);
      end
   end

   // Filter select follows the state being entered, so it flips on entry.
   always_comb begin
      sel_next = 2'b00;
      unique case (state_next)
         SEL_G:   sel_next = 2'b11;
         SEL_B:   sel_next = 2'b01;
         default: sel_next = 2'b00;
      endcase
   end

   // Registered filter select pins.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s2 <= sel_next[1];
         s3 <= sel_next[0];
      end
   end

   // Shadow capture on the last dwell cycle; an aborted frame clears them.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_s <= '0;
         g_s <= '0;
         b_s <= '0;
      end else if (in_sel && !en) begin
         r_s <= '0;
         g_s <= '0;
         b_s <= '0;
      end else if (dwell_last) begin
         if (state == SEL_R) r_s <= count_in;
         if (state == SEL_G) g_s <= count_in;
         if (state == SEL_B) b_s <= count_in;
      end
   end

   // Winner must be bright enough and clear both rivals by at least MARGIN.
   always_comb begin
      r_win = (r_s < DARK_THRESH) &&
              (g_s > r_s) && ((g_s - r_s) >= MARGIN) &&
              (b_s > r_s) && ((b_s - r_s) >= MARGIN);
      g_win = (g_s < DARK_THRESH) &&
              (r_s > g_s) && ((r_s - g_s) >= MARGIN) &&
              (b_s > g_s) && ((b_s - g_s) >= MARGIN);
      b_win = (b_s < DARK_THRESH) &&
              (r_s > b_s) && ((r_s - b_s) >= MARGIN) &&
              (g_s > b_s) && ((g_s - b_s) >= MARGIN);
      color_next = 2'b00;
      unique case (1'b1)
         r_win:   color_next = 2'b01;
         g_win:   color_next = 2'b10;
         b_win:   color_next = 2'b11;
         default: color_next = 2'b00;
      endcase
   end

   // Publish a completed frame on the edge leaving DECIDE.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         red_val     <= '0;
         green_val   <= '0;
         blue_val    <= '0;
         color       <= 2'b00;
         color_valid <= 1'b0;
      end else begin
         color_valid <= (state == DECIDE);
         if (state == DECIDE) begin
            red_val   <= r_s;
            green_val <= g_s;
            blue_val  <= b_s;
            color     <= color_next;
         end
      end
   end

endmodule

// File: tb/tb_color_classifier.sv
// tb_color_classifier: directed frame vectors plus abort, reset
// and back-to-back frame sequences for color_classifier.
module tb_color_classifier;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [7:0] count_in;
   logic       s2;
   logic       s3;
   logic [7:0] red_val;
   logic [7:0] green_val;
   logic [7:0] blue_val;
   logic [1:0] color;
   logic       color_valid;

   int n_vec  = 0;
   int n_fail = 0;
   int cyc    = 0;

   color_classifier #(
      .SETTLE_CYCLES(4),
      .MARGIN(8'd10),
      .DARK_THRESH(8'd200)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .en(en),
      .count_in(count_in),
      .s2(s2),
      .s3(s3),
      .red_val(red_val),
      .green_val(green_val),
      .blue_val(blue_val),
      .color(color),
      .color_valid(color_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
      logic [1:0] exp_color;
   } vec_t;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_outs(input string name, input logic [7:0] r,
                             input logic [7:0] g, input logic [7:0] b,
                             input logic [1:0] c);
      check({name, ".red_val"}, int'(red_val), int'(r));
      check({name, ".green_val"}, int'(green_val), int'(g));
      check({name, ".blue_val"}, int'(blue_val), int'(b));
      check({name, ".color"}, int'(color), int'(c));
   endtask

   // Caller sits on the observation point just before frame cycle 0,
   // or on cycle 0 itself when cont=1 (back-to-back frames).
   // Real counts appear only on the last dwell cycle of each filter.
   task automatic run_frame(input string name, input logic [7:0] r,
                            input logic [7:0] g, input logic [7:0] b,
                            input bit stay, input bit cont);
      logic [1:0] exp_sel;
      int bad_sel;
      int bad_vld;
      bad_sel = 0;
      bad_vld = 0;
      en = 1'b1;
      for (int k = 0; k < 13; k++) begin
         if (!(cont && k == 0)) tick();
         exp_sel = (k < 4) ? 2'b00 : (k < 8) ? 2'b11 :
                   (k < 12) ? 2'b01 : 2'b00;
         if ({s2, s3} != exp_sel) bad_sel++;
         if (color_valid && !(cont && k == 0)) bad_vld++;
         count_in = (k == 3) ? r : (k == 7) ? g :
                    (k == 11) ? b : 8'hEE;
         if (k == 12 && !stay) en = 1'b0;
      end
      tick();
      check({name, ".sel_seq_errs"}, bad_sel, 0);
      check({name, ".early_valid"}, bad_vld, 0);
      check({name, ".valid_at_13"}, int'(color_valid), 1);
   endtask

   vec_t vecs[6];

   initial begin
      int t1;
      int t2;
      vecs[0] = '{r: 8'd20,  g: 8'd80,  b: 8'd90,  exp_color: 2'b01};
      vecs[1] = '{r: 8'd50,  g: 8'd55,  b: 8'd90,  exp_color: 2'b00};
      vecs[2] = '{r: 8'd60,  g: 8'd60,  b: 8'd60,  exp_color: 2'b00};
      vecs[3] = '{r: 8'd250, g: 8'd250, b: 8'd250, exp_color: 2'b00};
      vecs[4] = '{r: 8'd199, g: 8'd230, b: 8'd240, exp_color: 2'b01};
      vecs[5] = '{r: 8'd100, g: 8'd30,  b: 8'd39,  exp_color: 2'b00};

      rst_n    = 1'b0;
      en       = 1'b1;
      count_in = 8'h55;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst.valid", int'(color_valid), 0);
      end
      check("rst.sel", int'({s2, s3}), 0);
      check_outs("rst", 8'd0, 8'd0, 8'd0, 2'b00);
      en = 1'b0;
      rst_n = 1'b1;
      tick();
      check("idle.sel", int'({s2, s3}), 0);

      for (int i = 0; i < 6; i++) begin
         run_frame($sformatf("vec%0d", i), vecs[i].r, vecs[i].g,
                   vecs[i].b, 1'b0, 1'b0);
         check_outs($sformatf("vec%0d", i), vecs[i].r, vecs[i].g,
                    vecs[i].b, vecs[i].exp_color);
         tick();
         check($sformatf("vec%0d.pulse_len", i), int'(color_valid), 0);
         check($sformatf("vec%0d.idle_sel", i), int'({s2, s3}), 0);
      end

      en = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         count_in = 8'd1;
         if (k == 5) en = 1'b0;
      end
      tick();
      check("abort.sel", int'({s2, s3}), 0);
      for (int k = 0; k < 16; k++) begin
         tick();
         if (color_valid) check("abort.no_valid", 1, 0);
      end
      check("abort.sel_idle", int'({s2, s3}), 0);
      check_outs("abort", 8'd100, 8'd30, 8'd39, 2'b00);

      en = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick();
         count_in = 8'd5;
      end
      check("midb.sel", int'({s2, s3}), 1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      en = 1'b0;
      check("midrst.sel", int'({s2, s3}), 0);
      check("midrst.valid", int'(color_valid), 0);
      check_outs("midrst", 8'd0, 8'd0, 8'd0, 2'b00);
      for (int k = 0; k < 16; k++) begin
         tick();
         if (color_valid) check("midrst.no_valid", 1, 0);
      end

      run_frame("cont0", 8'd90, 8'd80, 8'd20, 1'b1, 1'b0);
      t1 = cyc;
      check_outs("cont0", 8'd90, 8'd80, 8'd20, 2'b11);
      run_frame("cont1", 8'd90, 8'd15, 8'd70, 1'b0, 1'b1);
      t2 = cyc;
      check_outs("cont1", 8'd90, 8'd15, 8'd70, 2'b10);
      check("cont.spacing", t2 - t1, 13);
      tick();
      check("cont.pulse_len", int'(color_valid), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/color_classifier.md
# color_classifier

Downstream consumer of the frequency-counter stage in the line-follower colour-sensing path. It sequences the sensor's photodiode filter select through red, green and blue, waits a fixed dwell per filter and captures the 8-bit count for each channel. It then classifies the dominant colour once per frame. A larger count means a lower sensor frequency, which means lower intensity, so the dominant channel is the one with the smallest count.

## Interface
- SETTLE_CYCLES, 50000: clk cycles spent on each filter; count is sampled on the last cycle of the dwell (legal range 2..2^20).
- MARGIN, 8'd10: minimum amount by which the winning count must be below each of the other two.
- DARK_THRESH, 8'd200: if the smallest count is at or above this value, no colour is reported.
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  reset, synchronous, active-low.
- en  input  1  level enable; frames run back-to-back while high.
- count_in  input  8  count from the frequency-counter stage.
- s2  output  1  sensor filter select bit S2 (registered).
- s3  output  1  sensor filter select bit S3 (registered).
- red_val  output  8  last captured red count.
- green_val  output  8  last captured green count.
- blue_val  output  8  last captured blue count.
- color  output  2  classification: 00 none, 01 red, 10 green, 11 blue.
- color_valid  output  1  one-cycle pulse when color, red_val, green_val and blue_val are updated for a completed frame.

## Operation
- Filter encoding {s2,s3}: red 00, green 11, blue 01. In IDLE and DECIDE the outputs hold 00.
- FSM states and transitions:
  - IDLE: go to SEL_R when en=1.
  - SEL_R -> SEL_G -> SEL_B: advance when dwell_timer == SETTLE_CYCLES-1.
  - SEL_B -> DECIDE at the same condition.
  - DECIDE: go to SEL_R if en=1, otherwise IDLE.
- dwell_timer is cleared on every state entry and is wide enough for SETTLE_CYCLES-1. It never wraps within a state.
- Capture: on the final dwell edge of SEL_R, SEL_G and SEL_B, count_in is latched into an internal shadow register (r_s, g_s, b_s).
- DECIDE step 1: compute the classification from the shadow registers.
- DECIDE step 2: on the edge leaving DECIDE, copy the shadows to red_val, green_val and blue_val, register color, and pulse color_valid.
- Classification: channel w wins only if all of the following hold for both other channels o:
  - count_w < DARK_THRESH;
  - count_o > count_w;
  - (count_o - count_w) >= MARGIN.
  - All comparisons are unsigned 8-bit. The subtraction is done only when count_o > count_w, so it never underflows.
- If no channel wins, or the minima tie, color=00. color_valid still pulses in this case.
- en deasserted in any SEL state: go to IDLE on the next edge.
  - Shadows are discarded.
  - No color_valid pulse.
  - Published outputs keep their last values.
- en deasserted during DECIDE: the frame still completes and publishes, then the FSM goes to IDLE.

## Timing
- Reset (rst_n=0 at a posedge) sets:
  - state=IDLE, s2=0, s3=0;
  - dwell_timer=0, all shadows 0;
  - red_val, green_val, blue_val = 0;
  - color=00, color_valid=0.
- Reset has priority over en and applies mid-frame. Nothing is published from a frame aborted by reset.
- s2 and s3 change on the same edge that enters the new SEL state.
- Each SEL state lasts exactly SETTLE_CYCLES cycles. DECIDE lasts exactly 1 cycle.
- Frame period is 3*SETTLE_CYCLES+1 cycles. With en held high, color_valid pulses are exactly that far apart.
- color_valid goes high 3*SETTLE_CYCLES+1 cycles after the edge that entered SEL_R, and is high for exactly 1 cycle.
- color, red_val, green_val and blue_val are stable from the color_valid cycle until the next pulse or reset.
- count_in is sampled only on dwell-final edges. Changes at any other time are ignored.

## Test plan
All scenarios use SETTLE_CYCLES=4, MARGIN=10, DARK_THRESH=200.
- Reset: hold rst_n=0 for 3 cycles with en=1 and count_in=8'h55 -> all outputs 0, s2=s3=0, no color_valid.
- Red dominant: en=1; drive count_in=20 during red, 80 during green, 90 during blue -> color_valid 13 cycles after SEL_R entry, color=01, red_val=20, green_val=80, blue_val=90. Check the {s2,s3} sequence is 00 (4 cycles), 11 (4), 01 (4), 00 (1).
- Ambiguous: red=50, green=55, blue=90 -> color=00, color_valid still pulses. Then red=green=blue=60 -> color=00.
- Dark: all channels 250 -> color=00. Then red=199, green=230, blue=240 -> color=01.
- Abort: drop en on the 2nd cycle of SEL_G -> IDLE on the next edge, s2=s3=0, no color_valid, previous outputs retained. Pulse rst_n=0 mid-SEL_B -> outputs cleared.
- Continuous: en held high over two frames, blue-dominant (90,80,20) then green-dominant (90,15,70) -> color=11 then 10, with color_valid pulses exactly 13 cycles apart.
